// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch sequencer and its neighbours: button
// levels and CPU strobes in, counter/display controls and status out.
interface stopwatch_ctrl_if;
  // Buttons are debounced levels (an event fires on each rising edge).
  // CPU commands are strobes (each high cycle is one event).
  // tck_o and clr_o are one-cycle pulses, and the remaining outputs are levels.
  // There is no back-pressure: every output is valid every cycle.
  logic       b_run;
  logic       b_clr;
  logic       b_tmp;
  logic       c_run;
  logic       c_clr;
  logic       c_tmp;
  logic       tck_o;
  logic       clr_o;
  logic       dsp_o;
  logic       s_run;
  logic       s_hld;
  logic [1:0] dbg_state;

  modport master (
    output b_run, b_clr, b_tmp, c_run, c_clr, c_tmp,
    input  tck_o, clr_o, dsp_o, s_run, s_hld, dbg_state
  );

  modport slave (
    input  b_run, b_clr, b_tmp, c_run, c_clr, c_tmp,
    output tck_o, clr_o, dsp_o, s_run, s_hld, dbg_state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/stop/lap sequencer. Turns button edges and CPU strobes into
// state changes, and generates the BCD counter tick from a prescaler.
module stopwatch_ctrl #(
  parameter int FRQ = 24000000,
  parameter int TCK = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  stopwatch_ctrl_if.slave   bus
);

  localparam int DIV = FRQ / TCK;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    FRZ  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ps_q;
  logic          b_run_q, b_clr_q, b_tmp_q;
  logic          tck_q, clr_q, dsp_q, s_run_q, s_hld_q;
  logic          ev_run, ev_clr, ev_tmp;
  logic          clr_go, counting, wrap;

  assign ev_run = (bus.b_run & ~b_run_q) | bus.c_run;
  assign ev_clr = (bus.b_clr & ~b_clr_q) | bus.c_clr;
  assign ev_tmp = (bus.b_tmp & ~b_tmp_q) | bus.c_tmp;

  assign counting = (state_q == RUN) || (state_q == LAP);
  assign wrap     = counting && (ps_q == PS_LAST);

  // Priority is clr > run > tmp. An event that is illegal in a state falls
  // through to the next one, so only the top legal event is acted on.
  always_comb begin
    state_d = state_q;
    clr_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev_clr)      clr_go  = 1'b1;
        else if (ev_run) state_d = RUN;
      end
      RUN: begin
        if (ev_run)      state_d = IDLE;
        else if (ev_tmp) state_d = LAP;
      end
      LAP: begin
        if (ev_run)      state_d = FRZ;
        else if (ev_tmp) state_d = RUN;
      end
      FRZ: begin
        if (ev_clr) begin
          clr_go  = 1'b1;
          state_d = IDLE;
        end else if (ev_run) begin
          state_d = LAP;
        end else if (ev_tmp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The button history resets high so that a button held through reset is not
  // seen as a press. clr_o resets high so that the counter starts cleared.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ps_q    <= '0;
      b_run_q <= 1'b1;
      b_clr_q <= 1'b1;
      b_tmp_q <= 1'b1;
      tck_q   <= 1'b0;
      clr_q   <= 1'b1;
      dsp_q   <= 1'b1;
      s_run_q <= 1'b0;
      s_hld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      b_run_q <= bus.b_run;
      b_clr_q <= bus.b_clr;
      b_tmp_q <= bus.b_tmp;
      tck_q   <= wrap;
      clr_q   <= clr_go;
      if (clr_go || wrap) ps_q <= '0;
      else if (counting)  ps_q <= ps_q + 1'b1;
      s_run_q <= (state_d == RUN) || (state_d == LAP);
      s_hld_q <= (state_d == LAP) || (state_d == FRZ);
      dsp_q   <= !((state_d == LAP) || (state_d == FRZ));
    end
  end

  assign bus.tck_o     = tck_q;
  assign bus.clr_o     = clr_q;
  assign bus.dsp_o     = dsp_q;
  assign bus.s_run     = s_run_q;
  assign bus.s_hld     = s_hld_q;
  assign bus.dbg_state = state_q;

endmodule
